fcore_run_scheduler: RTL and testbench

- Sequences fCore program execution: issues single-cycle run pulses to the core from an internal periodic timer or an external trigger.
- Tracks completion through the core's done strobe and measures execution time in clock cycles.
- Detects overruns (trigger while busy) and hangs (timeout), and latches a fault.
- Sits between the GPIO/control register bank and the fCore run input, replacing the raw GPIO run drive.

---
 rtl/fcore_run_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_fcore_run_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcore_run_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fcore_run_scheduler
//  Purpose  : Issues single-cycle run pulses to the fCore. The trigger is an
//             internal period timer or a rising edge on an external trigger.
//             The block tracks completion through core_done and measures the
//             run length in cycles. A trigger that arrives while a run is in
//             progress is dropped and counted as an overrun. A run that
//             reaches the timeout latches a fault.
//  Options  : FCORE_SCHED_MAX_TIME_EN adds the max_exec_time output, which
//             holds the largest exec_time seen since reset or the last
//             fault clear.
//  Revision : 1.0 - initial release
// ============================================================================
module fcore_run_scheduler #(
  parameter int COUNTER_WIDTH = 32,
  parameter int OVERRUN_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     trigger_mode,
  input  logic [COUNTER_WIDTH-1:0] period,
  input  logic [COUNTER_WIDTH-1:0] timeout,
  input  logic                     ext_trigger,
  input  logic                     core_done,
  input  logic                     fault_clear,
  output logic                     run,
  output logic                     busy,
  output logic                     fault,
  output logic [COUNTER_WIDTH-1:0] exec_time,
  output logic [OVERRUN_WIDTH-1:0] overrun_count,
`ifdef FCORE_SCHED_MAX_TIME_EN
  output logic [COUNTER_WIDTH-1:0] max_exec_time,
`endif
  output logic [31:0]              run_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [OVERRUN_WIDTH-1:0] OVR_MAX = '1;

  state_t                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] timer_q, timer_d;
  logic [COUNTER_WIDTH-1:0] exec_q, exec_d;
  logic                     ext_trigger_q, ext_trigger_d;
  logic                     run_q, run_d;
  logic [COUNTER_WIDTH-1:0] exec_time_q, exec_time_d;
  logic [OVERRUN_WIDTH-1:0] overrun_q, overrun_d;
  logic [31:0]              run_count_q, run_count_d;
`ifdef FCORE_SCHED_MAX_TIME_EN
  logic [COUNTER_WIDTH-1:0] max_time_q, max_time_d;
`endif

  logic [COUNTER_WIDTH-1:0] period_last;
  logic                     timer_live;
  logic                     tick;
  logic                     ext_rise;
  logic                     trigger;
  logic [COUNTER_WIDTH-1:0] exec_inc;
  logic [OVERRUN_WIDTH-1:0] overrun_inc;
  logic                     timeout_hit;

  // Trigger sources and the saturating increments shared by the FSM.
  always_comb begin
    // The effective period is never shorter than 2 cycles.
    period_last = (period < COUNTER_WIDTH'(2)) ? COUNTER_WIDTH'(1)
                                               : period - COUNTER_WIDTH'(1);
    timer_live  = (state_q == ST_ARMED) || (state_q == ST_RUNNING);
    // The >= makes a period that shrinks mid-run wrap at once instead of
    // running through the whole counter range.
    tick        = timer_live && (timer_q >= period_last);
    ext_rise    = ext_trigger & ~ext_trigger_q;
    trigger     = trigger_mode ? ext_rise : tick;
    exec_inc    = (exec_q == CNT_MAX) ? exec_q : exec_q + COUNTER_WIDTH'(1);
    overrun_inc = (overrun_q == OVR_MAX) ? overrun_q
                                         : overrun_q + OVERRUN_WIDTH'(1);
    // exec_inc is the run length including the current cycle.
    timeout_hit = (timeout != '0) && (exec_inc == timeout);
  end

  // Next-state and register-update logic for the scheduler FSM.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    exec_d        = exec_q;
    ext_trigger_d = ext_trigger;
    run_d         = 1'b0;
    exec_time_d   = exec_time_q;
    overrun_d     = overrun_q;
    run_count_d   = run_count_q;
`ifdef FCORE_SCHED_MAX_TIME_EN
    max_time_d    = max_time_q;
`endif

    if (timer_live) begin
      timer_d = tick ? '0 : timer_q + COUNTER_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // Holding the timer at zero makes every arming start a full period.
        timer_d = '0;
        if (enable) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (trigger) begin
          state_d     = ST_RUNNING;
          run_d       = 1'b1;
          run_count_d = run_count_q + 32'd1;
          exec_d      = '0;
        end
      end

      ST_RUNNING: begin
        exec_d = exec_inc;
        if (core_done) begin
          // Completion beats both the timeout and an overrun in this cycle.
          exec_time_d = exec_inc;
`ifdef FCORE_SCHED_MAX_TIME_EN
          if (exec_inc > max_time_q) begin
            max_time_d = exec_inc;
          end
`endif
          if (!enable) begin
            // The scheduler is shutting down, so a coincident trigger
            // does not start a new run.
            state_d = ST_IDLE;
          end else if (trigger) begin
            // Back-to-back run: the state stays RUNNING with a fresh count.
            run_d       = 1'b1;
            run_count_d = run_count_q + 32'd1;
            exec_d      = '0;
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          if (trigger) begin
            overrun_d = overrun_inc;
          end
          if (timeout_hit) begin
            state_d = ST_FAULT;
          end
        end
      end

      ST_FAULT: begin
        // Triggers, done strobes and enable are all ignored until cleared.
        if (fault_clear) begin
          state_d = ST_IDLE;
`ifdef FCORE_SCHED_MAX_TIME_EN
          max_time_d = '0;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      exec_q        <= '0;
      ext_trigger_q <= 1'b0;
      run_q         <= 1'b0;
      exec_time_q   <= '0;
      overrun_q     <= '0;
      run_count_q   <= '0;
`ifdef FCORE_SCHED_MAX_TIME_EN
      max_time_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      exec_q        <= exec_d;
      ext_trigger_q <= ext_trigger_d;
      run_q         <= run_d;
      exec_time_q   <= exec_time_d;
      overrun_q     <= overrun_d;
      run_count_q   <= run_count_d;
`ifdef FCORE_SCHED_MAX_TIME_EN
      max_time_q    <= max_time_d;
`endif
    end
  end

  // Output drive. busy and fault decode the registered state directly.
  always_comb begin
    run           = run_q;
    busy          = (state_q == ST_RUNNING);
    fault         = (state_q == ST_FAULT);
    exec_time     = exec_time_q;
    overrun_count = overrun_q;
    run_count     = run_count_q;
`ifdef FCORE_SCHED_MAX_TIME_EN
    max_exec_time = max_time_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_fcore_run_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fcore_run_scheduler
//  Purpose  : Self-checking bench for fcore_run_scheduler. A timestamp-based
//             reference model predicts the outputs for every cycle. Directed
//             scenarios add hand-computed checks. A randomized phase follows.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fcore_run_scheduler;

  localparam int CW = 32;
  localparam int OW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          trigger_mode;
  logic [CW-1:0] period;
  logic [CW-1:0] timeout;
  logic          ext_trigger;
  logic          core_done;
  logic          fault_clear;
  logic          run;
  logic          busy;
  logic          fault;
  logic [CW-1:0] exec_time;
  logic [OW-1:0] overrun_count;
  logic [31:0]   run_count;
`ifdef FCORE_SCHED_MAX_TIME_EN
  logic [CW-1:0] max_exec_time;
`endif

  logic resp_done;
  logic man_done;
  int   done_delay;
  assign core_done = resp_done | man_done;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cyc   = 0;
  int run_times[$];

  fcore_run_scheduler #(.COUNTER_WIDTH(CW), .OVERRUN_WIDTH(OW)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .trigger_mode  (trigger_mode),
    .period        (period),
    .timeout       (timeout),
    .ext_trigger   (ext_trigger),
    .core_done     (core_done),
    .fault_clear   (fault_clear),
    .run           (run),
    .busy          (busy),
    .fault         (fault),
    .exec_time     (exec_time),
    .overrun_count (overrun_count),
`ifdef FCORE_SCHED_MAX_TIME_EN
    .max_exec_time (max_exec_time),
`endif
    .run_count     (run_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle index, advanced at each active edge.
  initial forever begin
    @(posedge clock);
    tb_cyc <= tb_cyc + 1;
  end

  // Record the cycle of every run pulse.
  initial forever begin
    @(negedge clock);
    if (run === 1'b1) run_times.push_back(tb_cyc);
  end

  // Core model: raises done_delay-1 cycles after the run pulse, 0 = never.
  initial begin
    int  age;
    bit  pend;
    resp_done = 1'b0;
    age  = 0;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      resp_done = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (run) begin
          pend = 1'b1;
          age  = 0;
        end else if (pend) begin
          age++;
        end
        if (pend && done_delay != 0 && age == done_delay - 1) begin
          resp_done = 1'b1;
          pend      = 1'b0;
        end
      end
    end
  end

  // Reference model. A run starts at a timestamp and its length is the
  // distance between timestamps. The timer tick is the arming phase modulo
  // the period.
  int          m_cyc = 0, m_arm = 0, m_start = 0;
  bit          m_live, m_running, m_fault, m_prev_ext;
  bit          exp_run;
  int          exp_exec, exp_ovr, exp_max;
  logic [31:0] exp_rc;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_live = 0; m_running = 0; m_fault = 0; m_prev_ext = 0;
      exp_run = 0; exp_exec = 0; exp_ovr = 0; exp_max = 0; exp_rc = '0;
    end else begin
      int p, len;
      bit trig;
      p    = (period < 2) ? 2 : int'(period);
      trig = trigger_mode ? (ext_trigger && !m_prev_ext)
                          : (m_live && ((m_cyc - m_arm) % p == p - 1));
      exp_run = 0;
      if (m_fault) begin
        if (fault_clear) begin
          m_fault = 0;
          exp_max = 0;
        end
      end else if (!m_live) begin
        if (enable) begin
          m_live = 1;
          m_arm  = m_cyc + 1;
        end
      end else if (!m_running) begin
        if (!enable) m_live = 0;
        else if (trig) begin
          m_running = 1; m_start = m_cyc + 1; exp_run = 1; exp_rc = exp_rc + 1;
        end
      end else begin
        len = m_cyc - m_start + 1;
        if (core_done) begin
          exp_exec = len;
          if (len > exp_max) exp_max = len;
          if (!enable) begin
            m_running = 0; m_live = 0;
          end else if (trig) begin
            m_start = m_cyc + 1; exp_run = 1; exp_rc = exp_rc + 1;
          end else begin
            m_running = 0;
          end
        end else begin
          if (trig && exp_ovr < 65535) exp_ovr++;
          if (timeout != 0 && len == int'(timeout)) begin
            m_fault = 1; m_running = 0; m_live = 0;
          end
        end
      end
      m_prev_ext = ext_trigger;
      m_cyc++;
    end
    #1;
    check("run", run, exp_run);
    check("busy", busy, m_running);
    check("fault", fault, m_fault);
    check("exec_time", exec_time, exp_exec);
    check("overrun_count", overrun_count, exp_ovr);
    check("run_count", run_count, exp_rc);
`ifdef FCORE_SCHED_MAX_TIME_EN
    check("max_exec_time", max_exec_time, exp_max);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    man_done = 1'b0; fault_clear = 1'b0; ext_trigger = 1'b0; enable = 1'b0;
    cyc(2);
    reset = 1'b0;
    run_times.delete();
  endtask

  task automatic wait_run(input int maxc);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clock);
      if (run) seen = 1;
    end
    check("wait_run_bound", seen, 1);
  endtask

  task automatic wait_idle(input int maxc);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clock);
      if (!busy) seen = 1;
    end
    check("wait_idle_bound", seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, rise_cyc;
    bit seen;
    reset = 1'b1; enable = 1'b0; trigger_mode = 1'b0; period = 10; timeout = 0;
    ext_trigger = 1'b0; man_done = 1'b0; fault_clear = 1'b0; done_delay = 0;
    cyc(2);
    check("reset_run", run, 0);
    check("reset_busy", busy, 0);
    check("reset_run_count", run_count, 0);

    // Internal timer, period 10, runs of 4 cycles, five runs.
    do_reset();
    trigger_mode = 0; period = 10; timeout = 0; done_delay = 4; enable = 1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (run_count == 5) seen = 1;
    end
    check("t1_five_runs_bound", seen, 1);
    enable = 0;
    wait_idle(50);
    cyc(2);
    check("t1_pulses", run_times.size(), 5);
    for (int i = 1; i < run_times.size(); i++)
      check("t1_spacing", run_times[i] - run_times[i-1], 10);
    check("t1_exec_time", exec_time, 4);
    check("t1_run_count", run_count, 5);
    check("t1_overrun", overrun_count, 0);

    // External trigger held high: one pulse, one cycle after the rising edge.
    do_reset();
    trigger_mode = 1; done_delay = 3; enable = 1;
    cyc(3);
    ext_trigger = 1; rise_cyc = tb_cyc; n0 = run_times.size();
    cyc(20);
    ext_trigger = 0; enable = 0;
    cyc(3);
    check("t2_pulses", run_times.size() - n0, 1);
    if (run_times.size() > n0) check("t2_latency", run_times[n0] - rise_cyc, 1);
    check("t2_exec_time", exec_time, 3);

    // Period 5 with 12-cycle runs: two dropped ticks.
    do_reset();
    trigger_mode = 0; period = 5; done_delay = 12; enable = 1;
    wait_run(20);
    wait_idle(30);
    enable = 0;
    cyc(4);
    check("t3_overrun", overrun_count, 2);
    check("t3_exec_time", exec_time, 12);
    check("t3_run_count", run_count, 1);

    // Timeout 8 without done: fault, triggers ignored, then cleared.
    do_reset();
    trigger_mode = 1; timeout = 8; done_delay = 0; enable = 1;
    cyc(2);
    ext_trigger = 1;
    wait_run(5);
    ext_trigger = 0;
    cyc(7);
    check("t4_busy_before_timeout", busy, 1);
    check("t4_fault_before_timeout", fault, 0);
    cyc(1);
    check("t4_fault_at_timeout", fault, 1);
    check("t4_busy_at_timeout", busy, 0);
    repeat (3) begin
      ext_trigger = 1; cyc(2); ext_trigger = 0; cyc(2);
    end
    check("t4_no_run_in_fault", run_count, 1);
    check("t4_no_overrun_in_fault", overrun_count, 0);
    check("t4_fault_held", fault, 1);
    fault_clear = 1; cyc(1); fault_clear = 0;
    check("t4_fault_cleared", fault, 0);
    enable = 0; cyc(2);

    // Done coincident with a trigger, then done coincident with the timeout.
    do_reset();
    trigger_mode = 1; timeout = 5; done_delay = 0; enable = 1;
    cyc(2);
    ext_trigger = 1;
    wait_run(5);
    ext_trigger = 0;
    cyc(2);
    man_done = 1; ext_trigger = 1;
    cyc(1);
    man_done = 0; ext_trigger = 0;
    check("t5_b2b_run", run, 1);
    check("t5_b2b_busy", busy, 1);
    check("t5_b2b_overrun", overrun_count, 0);
    check("t5_b2b_exec_time", exec_time, 3);
    check("t5_b2b_run_count", run_count, 2);
    cyc(4);
    man_done = 1;
    cyc(1);
    man_done = 0;
    check("t5_done_beats_timeout", fault, 0);
    check("t5_done_busy", busy, 0);
    check("t5_done_exec_time", exec_time, 5);
    timeout = 0; enable = 0; cyc(2);

    // Asynchronous reset two cycles into a run.
    do_reset();
    trigger_mode = 1; done_delay = 3; enable = 1;
    cyc(2);
    ext_trigger = 1;
    wait_run(5);
    ext_trigger = 0;
    wait_idle(10);
    cyc(1);
    ext_trigger = 1;
    wait_run(5);
    ext_trigger = 0;
    @(negedge clock);
    @(posedge clock);
    #3 reset = 1;
    #1;
    check("t6_async_run", run, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_run_count", run_count, 0);
    check("t6_async_exec_time", exec_time, 0);
    @(negedge clock);
    enable = 0;
    cyc(2);
    reset = 0;
    cyc(1);
    ext_trigger = 1; cyc(3); ext_trigger = 0;
    check("t6_idle_after_reset", run_count, 0);
    check("t6_not_busy", busy, 0);

    // Randomized phase, checked every cycle by the model.
    do_reset();
    enable = 1; trigger_mode = 0; period = 6; timeout = 0; done_delay = 3;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 999) < 15) enable = ~enable;
      if ($urandom_range(0, 999) < 5)  trigger_mode = ~trigger_mode;
      if ($urandom_range(0, 99) < 15)  ext_trigger = ~ext_trigger;
      fault_clear = ($urandom_range(0, 99) < 4);
      man_done    = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 2) done_delay = $urandom_range(0, 14);
      if ($urandom_range(0, 99) < 2) begin
        case ($urandom_range(0, 5))
          0, 1:    timeout = 0;
          2:       timeout = 5;
          3:       timeout = 9;
          4:       timeout = 13;
          default: timeout = 20;
        endcase
      end
      if (!m_live && !m_fault && $urandom_range(0, 99) < 10)
        period = $urandom_range(0, 12);
    end
    man_done = 0; fault_clear = 0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
